fnd_scan_ctrl: RTL and testbench

Parametrised multi-digit 7-segment display controller for the board FND. It accepts a binary value on a load strobe and converts it to BCD with a sequential shift-add-3 engine, so no combinational divide/modulo is needed. It time-multiplexes DIGITS common-anode digits with per-digit decimal points, overflow indication and optional leading-zero blanking. It sits between the counter/SPI datapath and the FND pins.

---
 rtl/fnd_pkg.sv | 16 +
 rtl/bin2bcd_seq.sv | 61 ++++++
 rtl/fnd_scan_ctrl.sv | 73 +++++++
 tb/tb_fnd_scan_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared segment encodings, converter states and helpers for the FND controller.
package fnd_pkg;
  typedef logic [7:0] seg_t;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;
  localparam seg_t SEG_BLANK = 8'hFF;
  localparam seg_t SEG_DASH = 8'hBF;
  localparam seg_t SEG_LUT [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                     8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  function automatic logic [31:0] pow10(input int n);
    pow10 = 32'd1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 32'd10;
  endfunction
  function automatic seg_t seg_of(input logic [3:0] n);
    return n > 4'd9 ? SEG_BLANK : SEG_LUT[n];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);
  localparam int CW = $clog2(BIN_W + 1);
  conv_state_t state_q;
  logic [BIN_W-1:0] bin_q;
  logic [CW-1:0] cnt_q;
  logic [4*DIGITS-1:0] bcd_adj;
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++)
      bcd_adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd <= '0;
      cnt_q <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          bin_q <= bin;
          bcd <= '0;
          ovf <= 32'(bin) >= pow10(DIGITS);
          cnt_q <= CW'(BIN_W);
          busy <= 1'b1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          {bcd, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= COMMIT;
            done <= 1'b1;
          end
        end
        default: begin
          busy <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: multiplexed common-anode 7-segment driver with sequential BCD conversion.
// Define FND_LZB_EN to blank leading zeros.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  input  logic [DIGITS-1:0] dp,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] fnd_com,
  output logic [7:0]        fnd_data
);
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef FND_LZB_EN
  localparam bit LZB_EN = 1'b1;
`else
  localparam bit LZB_EN = 1'b0;
`endif
  logic [PW-1:0] presc_q;
  logic [IW-1:0] idx_q;
  logic [4*DIGITS-1:0] digit_q, bcd;
  logic ovf_q, ovf_pend, done, tick;
  logic [DIGITS:0] zero_hi;
  seg_t pat;
  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_conv (
    .clk(clk), .rst(rst), .start(load), .bin(value),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf_pend)
  );
  assign tick = presc_q == PW'(SCAN_DIV - 1);
  assign ovf = ovf_q;
  // zero_hi[k] is set when digit k and every digit above it are zero
  always_comb begin
    zero_hi = '0;
    zero_hi[DIGITS] = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--)
      zero_hi[k] = zero_hi[k+1] && digit_q[4*k+:4] == 4'd0;
  end
  always_comb begin
    pat = ovf_q ? SEG_DASH
        : (LZB_EN && idx_q != '0 && zero_hi[idx_q]) ? SEG_BLANK
        : seg_of(digit_q[{idx_q, 2'b00}+:4]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc_q <= '0;
      idx_q <= '0;
      digit_q <= '0;
      ovf_q <= 1'b0;
      fnd_com <= '1;
      fnd_data <= SEG_BLANK;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (done) begin
        digit_q <= bcd;
        ovf_q <= ovf_pend;
      end
      if (tick) begin
        fnd_com <= ~(DIGITS'(1) << idx_q);
        fnd_data <= {~dp[idx_q], pat[6:0]};
        idx_q <= idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1;
      end
    end
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// tb_fnd_scan_ctrl: scoreboard bench; stimulus queues expected scan frames, monitor checks on each digit change.
module tb_fnd_scan_ctrl;
  logic clk, rst, load, busy, ovf;
  logic [13:0] value;
  logic [3:0] dp, fnd_com;
  logic [7:0] fnd_data;
  int checks = 0, errors = 0, cyc = 0, eidx = 0;
  logic [31:0] exp_pat;
  logic [11:0] q[$];
`ifdef FND_LZB_EN
  localparam logic [31:0] P_ZERO = 32'hFFFFFFC0, P_SEVEN = 32'hFFFFFFF8,
                          P_42 = 32'hFFFF99A4, P_FIVE = 32'hFFFFFF92;
`else
  localparam logic [31:0] P_ZERO = 32'hC0C0C0C0, P_SEVEN = 32'hC0C0C0F8,
                          P_42 = 32'hC0C099A4, P_FIVE = 32'hC0C0C092;
`endif
  localparam logic [31:0] P_1234 = 32'hF9A4B099, P_9999 = 32'h90909090, P_OVF = 32'hBFBFBFBF;

  fnd_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp(dp),
    .busy(busy), .ovf(ovf), .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // one clock; on scan-tick edges queue the frame the display should latch
  task automatic step();
    logic [7:0] b;
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % 10 == 0) begin
      b = exp_pat[eidx*8+:8];
      q.push_back({~(4'b0001 << eidx), ~dp[eidx], b[6:0]});
      eidx = (eidx + 1) % 4;
    end
  endtask

  task automatic run40();
    repeat (40) step();
  endtask

  task automatic do_load(input int v, input logic [31:0] pat, input logic ovf_e,
                         input int extra_at, input int v2);
    value = 14'(v);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("busy_start", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 14; i++) begin
      if (i == extra_at) begin
        value = 14'(v2);
        load = 1'b1;
      end
      step();
      load = 1'b0;
      value = 14'(v);
      chk("busy_mid", {31'd0, busy}, 32'd1);
    end
    step();
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("ovf", {31'd0, ovf}, {31'd0, ovf_e});
    exp_pat = pat;
  endtask

  task automatic chk_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_com", {28'd0, fnd_com}, 32'hF);
    chk("rst_data", {24'd0, fnd_data}, 32'hFF);
  endtask

  initial begin
    logic [3:0] prev;
    logic [11:0] e;
    prev = 4'hF;
    forever begin
      @(negedge clk);
      if (rst) prev = 4'hF;
      else if (fnd_com != prev) begin
        prev = fnd_com;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL scan_unexpected got %h_%h expected none", fnd_com, fnd_data);
        end else begin
          e = q.pop_front();
          if ({fnd_com, fnd_data} !== e) begin
            errors++;
            $display("FAIL scan got %h_%h expected %h_%h", fnd_com, fnd_data, e[11:8], e[7:0]);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    load = 1'b0;
    value = '0;
    dp = '0;
    exp_pat = P_ZERO;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst = 1'b0;
    run40();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    do_load(1234, P_1234, 1'b0, 0, 0);
    run40();
    do_load(9999, P_9999, 1'b0, 0, 0);
    run40();
    do_load(10000, P_OVF, 1'b1, 0, 0);
    run40();
    do_load(7, P_SEVEN, 1'b0, 0, 0);
    run40();
    dp = 4'b0010;
    run40();
    dp = 4'b0000;
    do_load(42, P_42, 1'b0, 3, 99);
    run40();
    while (cyc % 10 != 9) step();
    do_load(1234, P_1234, 1'b0, 0, 0);
    run40();
    while (cyc % 10 != 4) step();
    do_load(9999, P_9999, 1'b0, 0, 0);
    run40();
    do_load(10000, P_OVF, 1'b1, 0, 0);
    run40();
    while (cyc % 10 != 9) step();
    value = 14'd3333;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    #1;
    chk_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    eidx = 0;
    exp_pat = P_ZERO;
    run40();
    do_load(5, P_FIVE, 1'b0, 0, 0);
    run40();
    repeat (3) step();
    chk("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
